delay_step_ctrl: RTL and testbench

- Sequencer for one dynamic input-delay cell (LOADN/MOVE/DIRECTION/CFLAG style), sitting between training/calibration logic and the I/O delay primitive.
- Accepts a target tap code over a valid/ready handshake and walks the cell to it one tap at a time with a programmable settle gap.
- Tracks the current tap code and flags range violations reported by the cell.
- Performs an automatic reload to the default code after reset.

---
 rtl/delay_ctrl_pkg.sv | 20 ++
 rtl/delay_code_tracker.sv | 65 ++++++
 rtl/delay_step_ctrl.sv | 146 ++++++++++++++
 tb/tb_delay_step_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_ctrl_pkg.sv
// Shared types and constants for the dynamic input-delay step controller.
package delay_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    PREP,
    STEP,
    SETTLE,
    FIN
  } ctrl_state_t;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  localparam int TAP_CODE_W = 7;
  typedef logic [TAP_CODE_W-1:0] tap_code_t;

endpackage

// File: rtl/delay_code_tracker.sv
// Shadow copy of the delay cell's tap code: saturating single steps, reload to
// default, and reversal of the most recent step when the cell flags a limit.
module delay_code_tracker
  import delay_ctrl_pkg::*;
#(
  parameter int CODE_W       = 7,
  parameter int MAX_CODE     = 127,
  parameter int DEFAULT_CODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_default,
  input  logic              step_en,
  input  logic              step_dir,
  input  logic              undo,
  input  logic [CODE_W-1:0] tgt,
  output logic [CODE_W-1:0] cur_code,
  output logic              tgt_eq,
  output logic              tgt_lt,
  output logic              step_hits_tgt
);

  localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_CODE);
  localparam logic [CODE_W-1:0] DEF_C = CODE_W'(DEFAULT_CODE);

  logic [CODE_W-1:0] stepped;
  logic              last_moved;
  logic              last_dir;

  always_comb begin
    stepped = cur_code;
    if (step_dir == DIR_DEC) begin
      if (cur_code != '0) stepped = cur_code - CODE_W'(1);
    end else begin
      if (cur_code != MAX_C) stepped = cur_code + CODE_W'(1);
    end
  end

  // A saturated step leaves the code unchanged, so only a real move is undone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_code   <= DEF_C;
      last_moved <= 1'b0;
      last_dir   <= DIR_INC;
    end else if (load_default) begin
      cur_code   <= DEF_C;
      last_moved <= 1'b0;
    end else if (undo) begin
      if (last_moved) begin
        if (last_dir == DIR_DEC) cur_code <= cur_code + CODE_W'(1);
        else                     cur_code <= cur_code - CODE_W'(1);
      end
      last_moved <= 1'b0;
    end else if (step_en) begin
      cur_code   <= stepped;
      last_moved <= (stepped != cur_code);
      last_dir   <= step_dir;
    end
  end

  assign tgt_eq        = (cur_code == tgt);
  assign tgt_lt        = (tgt < cur_code);
  assign step_hits_tgt = (stepped == tgt);

endmodule

// File: rtl/delay_step_ctrl.sv
// Walks one dynamic input-delay cell to a requested tap code, one MOVE pulse at
// a time with a settle gap, and reloads the cell to its default after reset.
module delay_step_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int CODE_W       = 7,
  parameter int MAX_CODE     = 127,
  parameter int DEFAULT_CODE = 0,
  parameter int LOAD_CYC     = 4,
  parameter int SETTLE_CYC   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [CODE_W-1:0] cur_code,
  output logic              loadn,
  output logic              move,
  output logic              direction,
  input  logic              cflag
);

  localparam int CNT_MAX = (LOAD_CYC > SETTLE_CYC) ? LOAD_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  ctrl_state_t       state;
  ctrl_state_t       state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] tgt_q;
  logic [CODE_W-1:0] req_clamped;
  logic              dir_q;
  logic              hs;
  logic              tgt_eq;
  logic              tgt_lt;
  logic              step_hits_tgt;
  logic              load_default;
  logic              step_en;
  logic              undo;

  // Clamping is only needed when the code field can express values above MAX_CODE.
  generate
    if (MAX_CODE < (2 ** CODE_W) - 1) begin : g_clamp
      always_comb begin
        req_clamped = req_code;
        if ({1'b0, req_code} > (CODE_W + 1)'(MAX_CODE)) req_clamped = CODE_W'(MAX_CODE);
      end
    end else begin : g_no_clamp
      assign req_clamped = req_code;
    end
  endgenerate

  assign hs = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      INIT: state_d = LOAD;
      IDLE: begin
        if (req_valid) begin
          if (req_load)                     state_d = LOAD;
          else if (req_clamped == cur_code) state_d = FIN;
          else                              state_d = PREP;
        end
      end
      LOAD: if (cnt == CNT_W'(LOAD_CYC - 1)) state_d = FIN;
      PREP: state_d = STEP;
      // With no settle gap the arrival decision is made on the post-step code.
      STEP: begin
        if (cflag)                state_d = FIN;
        else if (SETTLE_CYC != 0) state_d = SETTLE;
        else if (step_hits_tgt)   state_d = FIN;
        else                      state_d = PREP;
      end
      SETTLE: begin
        if (cflag)                                state_d = FIN;
        else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_d = tgt_eq ? FIN : PREP;
      end
      FIN:     state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    done      = (state == FIN);
    loadn     = (state != LOAD);
    move      = (state == STEP);
    direction = (state == PREP) ? tgt_lt : dir_q;
  end

  // Counts cycles spent in LOAD and SETTLE; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == LOAD || state == SETTLE) && state_d == state) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= CODE_W'(DEFAULT_CODE);
      dir_q <= DIR_INC;
      err   <= 1'b0;
    end else begin
      if (hs && !req_load) tgt_q <= req_clamped;
      if (state == PREP)   dir_q <= tgt_lt;
      if (hs)                                              err <= 1'b0;
      else if (cflag && (state == STEP || state == SETTLE)) err <= 1'b1;
    end
  end

  assign load_default = (state == LOAD) && (cnt == CNT_W'(LOAD_CYC - 1));
  assign step_en      = (state == STEP) && !cflag;
  assign undo         = (state == SETTLE) && cflag;

  delay_code_tracker #(
    .CODE_W      (CODE_W),
    .MAX_CODE    (MAX_CODE),
    .DEFAULT_CODE(DEFAULT_CODE)
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_default (load_default),
    .step_en      (step_en),
    .step_dir     (dir_q),
    .undo         (undo),
    .tgt          (tgt_q),
    .cur_code     (cur_code),
    .tgt_eq       (tgt_eq),
    .tgt_lt       (tgt_lt),
    .step_hits_tgt(step_hits_tgt)
  );

endmodule

// File: tb/tb_delay_step_ctrl.sv
// Self-checking bench for delay_step_ctrl: scenario tasks plus randomized
// requests compared against an arithmetic model of tap walks, loads and limits.
module tb_delay_step_ctrl;

  localparam int CODE_W       = 8;
  localparam int MAX_CODE     = 127;
  localparam int DEFAULT_CODE = 0;
  localparam int LOAD_CYC     = 4;
  localparam int SETTLE_CYC   = 3;
  localparam int STEP_CYC     = SETTLE_CYC + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_load = 1'b0;
  logic [CODE_W-1:0] req_code = '0;
  logic              cflag = 1'b0;
  logic              req_ready, done, err, loadn, move, direction;
  logic [CODE_W-1:0] cur_code;

  int checks = 0;
  int passed = 0;
  int m_code = DEFAULT_CODE;

  int   o_lat, o_moves, o_nlow, o_gap_min, o_gap_max, o_busy_ready;
  logic o_dir_or, o_dir_and, o_timeout;
  int   e_lat, e_moves, e_code, e_nlow;
  logic e_dir, e_err;
  int   r_first, r_nlow, r_done, r_ready;

  always #5 clk = ~clk;

  delay_step_ctrl #(
    .CODE_W      (CODE_W),
    .MAX_CODE    (MAX_CODE),
    .DEFAULT_CODE(DEFAULT_CODE),
    .LOAD_CYC    (LOAD_CYC),
    .SETTLE_CYC  (SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_load (req_load),
    .req_code (req_code),
    .req_ready(req_ready),
    .done     (done),
    .err      (err),
    .cur_code (cur_code),
    .loadn    (loadn),
    .move     (move),
    .direction(direction),
    .cflag    (cflag)
  );

  // Expected outcome of one request, from the tap-walk rules alone.
  task automatic model_request(input logic ld, input int code, input int inj_step, input int inj_off);
    int tgt, n;
    tgt   = (code > MAX_CODE) ? MAX_CODE : code;
    e_dir = (tgt < m_code);
    e_err = 1'b0;
    e_nlow = ld ? LOAD_CYC : 0;
    if (ld) begin
      e_lat = LOAD_CYC + 1; e_moves = 0; e_code = DEFAULT_CODE;
    end else begin
      n = (tgt > m_code) ? tgt - m_code : m_code - tgt;
      if (n == 0) begin
        e_lat = 1; e_moves = 0; e_code = m_code;
      end else if (inj_step > 0 && inj_step <= n) begin
        e_moves = inj_step;
        e_lat   = (inj_step - 1) * STEP_CYC + 4 + inj_off;
        e_code  = e_dir ? m_code - (inj_step - 1) : m_code + (inj_step - 1);
        e_err   = 1'b1;
      end else begin
        e_moves = n; e_lat = n * STEP_CYC + 1; e_code = tgt;
      end
    end
    m_code = e_code;
  endtask

  // Issues one request and records what the cell interface did until DONE.
  task automatic do_request(input logic ld, input int code, input int inj_step, input int inj_off,
                            input logic hold, input int alt_code);
    int   since, last_move, budget;
    logic prev_dir;
    o_lat = -1; o_moves = 0; o_nlow = 0; o_gap_min = 1 << 30; o_gap_max = 0;
    o_dir_or = 1'b0; o_dir_and = 1'b1; o_timeout = 1'b0; o_busy_ready = 0;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(posedge clk); #1; budget++;
    end
    if (!req_ready) begin
      o_timeout = 1'b1;
      return;
    end
    req_valid = 1'b1; req_load = ld; req_code = CODE_W'(code);
    prev_dir = direction;
    @(posedge clk); #1;
    if (hold) begin
      req_load = 1'b0; req_code = CODE_W'(alt_code);
    end else begin
      req_valid = 1'b0;
    end
    since = 0; last_move = 0;
    for (int c = 1; c <= 3000; c++) begin
      if (move) begin
        o_moves++;
        if (o_moves > 1) begin
          if (c - last_move < o_gap_min) o_gap_min = c - last_move;
          if (c - last_move > o_gap_max) o_gap_max = c - last_move;
        end
        last_move = c; since = 0;
        o_dir_or  = o_dir_or | direction | prev_dir;
        o_dir_and = o_dir_and & direction & prev_dir;
      end else begin
        since++;
      end
      if (!loadn) o_nlow++;
      if (req_ready) o_busy_ready++;
      if (done) begin
        o_lat = c;
        break;
      end
      cflag = (inj_step > 0 && o_moves == inj_step && since == inj_off + 1);
      prev_dir = direction;
      @(posedge clk); #1;
    end
    cflag = 1'b0;
    if (o_lat < 0) o_timeout = 1'b1;
  endtask

  // Called at the sample point of the cycle in which rst_n has just risen.
  task automatic observe_post_reset();
    r_first = -1; r_nlow = 0; r_done = -1; r_ready = -1;
    for (int c = 1; c <= 40; c++) begin
      if (!loadn) begin
        if (r_first < 0) r_first = c;
        r_nlow++;
      end
      if (done && r_done < 0) r_done = c;
      if (req_ready) begin
        r_ready = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; cflag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({loadn, move, req_ready, done, err, direction} !== 6'b100000)
      $display("[TB] FAIL reset_outputs got=%b want=100000", {loadn, move, req_ready, done, err, direction}); else passed++;
    checks++; if (cur_code !== CODE_W'(DEFAULT_CODE))
      $display("[TB] FAIL reset_code got=%0d want=%0d", cur_code, DEFAULT_CODE); else passed++;
    rst_n = 1'b1;
    observe_post_reset();
    m_code = DEFAULT_CODE;
    checks++; if (r_first !== 2) $display("[TB] FAIL reset_loadn_start got=%0d want=2", r_first); else passed++;
    checks++; if (r_nlow !== LOAD_CYC) $display("[TB] FAIL reset_loadn_len got=%0d want=%0d", r_nlow, LOAD_CYC); else passed++;
    checks++; if (r_done !== 2 + LOAD_CYC) $display("[TB] FAIL reset_done_cycle got=%0d want=%0d", r_done, 2 + LOAD_CYC); else passed++;
    checks++; if (r_ready !== 3 + LOAD_CYC) $display("[TB] FAIL reset_ready_cycle got=%0d want=%0d", r_ready, 3 + LOAD_CYC); else passed++;
    checks++; if (cur_code !== CODE_W'(DEFAULT_CODE)) $display("[TB] FAIL reset_final_code got=%0d want=%0d", cur_code, DEFAULT_CODE); else passed++;
  endtask

  task automatic test_step_up();
    model_request(1'b0, 5, 0, 0);
    do_request(1'b0, 5, 0, 0, 1'b0, 0);
    checks++; if (o_timeout) $display("[TB] FAIL up_timeout got=1 want=0"); else passed++;
    checks++; if (o_lat !== e_lat) $display("[TB] FAIL up_latency got=%0d want=%0d", o_lat, e_lat); else passed++;
    checks++; if (o_moves !== e_moves) $display("[TB] FAIL up_moves got=%0d want=%0d", o_moves, e_moves); else passed++;
    checks++; if (o_gap_min !== STEP_CYC || o_gap_max !== STEP_CYC)
      $display("[TB] FAIL up_gap got=%0d..%0d want=%0d", o_gap_min, o_gap_max, STEP_CYC); else passed++;
    checks++; if (o_dir_or !== 1'b0) $display("[TB] FAIL up_direction got=%b want=0", o_dir_or); else passed++;
    checks++; if (cur_code !== CODE_W'(e_code)) $display("[TB] FAIL up_code got=%0d want=%0d", cur_code, e_code); else passed++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL up_err got=%b want=0", err); else passed++;
  endtask

  task automatic test_step_down_same();
    model_request(1'b0, 2, 0, 0);
    do_request(1'b0, 2, 0, 0, 1'b0, 0);
    checks++; if (o_lat !== e_lat) $display("[TB] FAIL down_latency got=%0d want=%0d", o_lat, e_lat); else passed++;
    checks++; if (o_moves !== e_moves) $display("[TB] FAIL down_moves got=%0d want=%0d", o_moves, e_moves); else passed++;
    checks++; if (o_dir_and !== 1'b1) $display("[TB] FAIL down_direction got=%b want=1", o_dir_and); else passed++;
    checks++; if (cur_code !== CODE_W'(e_code)) $display("[TB] FAIL down_code got=%0d want=%0d", cur_code, e_code); else passed++;
    model_request(1'b0, 2, 0, 0);
    do_request(1'b0, 2, 0, 0, 1'b0, 0);
    checks++; if (o_lat !== e_lat) $display("[TB] FAIL same_latency got=%0d want=%0d", o_lat, e_lat); else passed++;
    checks++; if (o_moves !== 0) $display("[TB] FAIL same_moves got=%0d want=0", o_moves); else passed++;
  endtask

  task automatic test_clamp_cflag();
    model_request(1'b1, 0, 0, 0);
    do_request(1'b1, 0, 0, 0, 1'b0, 0);
    model_request(1'b0, 200, 3, 1);
    do_request(1'b0, 200, 3, 1, 1'b0, 0);
    checks++; if (o_lat !== e_lat) $display("[TB] FAIL cflag_latency got=%0d want=%0d", o_lat, e_lat); else passed++;
    checks++; if (o_moves !== 3) $display("[TB] FAIL cflag_moves got=%0d want=3", o_moves); else passed++;
    checks++; if (err !== 1'b1) $display("[TB] FAIL cflag_err got=%b want=1", err); else passed++;
    checks++; if (cur_code !== CODE_W'(e_code)) $display("[TB] FAIL cflag_code got=%0d want=%0d", cur_code, e_code); else passed++;
    model_request(1'b0, 123, 0, 0);
    do_request(1'b0, 123, 0, 0, 1'b0, 0);
    checks++; if (err !== 1'b0) $display("[TB] FAIL err_clear got=%b want=0", err); else passed++;
    model_request(1'b0, 200, 0, 0);
    do_request(1'b0, 200, 0, 0, 1'b0, 0);
    checks++; if (o_moves !== e_moves) $display("[TB] FAIL clamp_moves got=%0d want=%0d", o_moves, e_moves); else passed++;
    checks++; if (cur_code !== CODE_W'(MAX_CODE)) $display("[TB] FAIL clamp_code got=%0d want=%0d", cur_code, MAX_CODE); else passed++;
    model_request(1'b0, 255, 0, 0);
    do_request(1'b0, 255, 0, 0, 1'b0, 0);
    checks++; if (o_lat !== e_lat || o_moves !== 0)
      $display("[TB] FAIL clamp_same got=%0d/%0d want=%0d/0", o_lat, o_moves, e_lat); else passed++;
    model_request(1'b0, 0, 2, -1);
    do_request(1'b0, 0, 2, -1, 1'b0, 0);
    checks++; if (o_lat !== e_lat) $display("[TB] FAIL stepflag_latency got=%0d want=%0d", o_lat, e_lat); else passed++;
    checks++; if (cur_code !== CODE_W'(e_code) || err !== 1'b1)
      $display("[TB] FAIL stepflag_code got=%0d/%b want=%0d/1", cur_code, err, e_code); else passed++;
  endtask

  task automatic test_busy_load();
    model_request(1'b0, 20, 0, 0);
    do_request(1'b0, 20, 0, 0, 1'b1, 9);
    checks++; if (o_busy_ready !== 0) $display("[TB] FAIL busy_ready got=%0d want=0", o_busy_ready); else passed++;
    checks++; if (cur_code !== CODE_W'(e_code) || o_moves !== e_moves)
      $display("[TB] FAIL busy_first got=%0d/%0d want=%0d/%0d", cur_code, o_moves, e_code, e_moves); else passed++;
    model_request(1'b0, 9, 0, 0);
    do_request(1'b0, 9, 0, 0, 1'b0, 0);
    checks++; if (cur_code !== CODE_W'(e_code) || o_lat !== e_lat)
      $display("[TB] FAIL busy_second got=%0d/%0d want=%0d/%0d", cur_code, o_lat, e_code, e_lat); else passed++;
    model_request(1'b1, 77, 0, 0);
    do_request(1'b1, 77, 0, 0, 1'b0, 0);
    checks++; if (o_nlow !== e_nlow) $display("[TB] FAIL load_len got=%0d want=%0d", o_nlow, e_nlow); else passed++;
    checks++; if (o_moves !== 0) $display("[TB] FAIL load_moves got=%0d want=0", o_moves); else passed++;
    checks++; if (o_lat !== e_lat) $display("[TB] FAIL load_latency got=%0d want=%0d", o_lat, e_lat); else passed++;
    checks++; if (cur_code !== CODE_W'(e_code)) $display("[TB] FAIL load_code got=%0d want=%0d", cur_code, e_code); else passed++;
  endtask

  task automatic test_reset_mid_move();
    int budget;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(posedge clk); #1; budget++;
    end
    req_valid = 1'b1; req_load = 1'b0; req_code = CODE_W'(10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    budget = 0;
    while (!move && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    checks++; if (move !== 1'b1) $display("[TB] FAIL midreset_reach_move got=%b want=1", move); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({loadn, move, req_ready, done, err, direction} !== 6'b100000)
      $display("[TB] FAIL midreset_outputs got=%b want=100000", {loadn, move, req_ready, done, err, direction}); else passed++;
    checks++; if (cur_code !== CODE_W'(DEFAULT_CODE))
      $display("[TB] FAIL midreset_code got=%0d want=%0d", cur_code, DEFAULT_CODE); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    observe_post_reset();
    m_code = DEFAULT_CODE;
    checks++; if (r_first !== 2 || r_nlow !== LOAD_CYC || r_done !== 2 + LOAD_CYC || r_ready !== 3 + LOAD_CYC)
      $display("[TB] FAIL midreset_reload got=%0d/%0d/%0d/%0d want=2/%0d/%0d/%0d",
               r_first, r_nlow, r_done, r_ready, LOAD_CYC, 2 + LOAD_CYC, 3 + LOAD_CYC); else passed++;
  endtask

  task automatic test_random();
    logic ld;
    int   code, inj_step, inj_off;
    for (int i = 0; i < 12; i++) begin
      ld = ($urandom_range(0, 6) == 0);
      code = int'($urandom_range(0, 255));
      inj_step = 0; inj_off = 0;
      if ($urandom_range(0, 2) == 0) begin
        inj_step = int'($urandom_range(1, 4));
        inj_off  = int'($urandom_range(0, SETTLE_CYC)) - 1;
      end
      model_request(ld, code, inj_step, inj_off);
      do_request(ld, code, inj_step, inj_off, 1'b0, 0);
      checks++; if (o_lat !== e_lat) $display("[TB] FAIL rand%0d_latency got=%0d want=%0d", i, o_lat, e_lat); else passed++;
      checks++; if (o_moves !== e_moves) $display("[TB] FAIL rand%0d_moves got=%0d want=%0d", i, o_moves, e_moves); else passed++;
      checks++; if (cur_code !== CODE_W'(e_code)) $display("[TB] FAIL rand%0d_code got=%0d want=%0d", i, cur_code, e_code); else passed++;
      checks++; if (err !== e_err) $display("[TB] FAIL rand%0d_err got=%b want=%b", i, err, e_err); else passed++;
      checks++; if (o_nlow !== e_nlow) $display("[TB] FAIL rand%0d_loadn got=%0d want=%0d", i, o_nlow, e_nlow); else passed++;
      if (e_moves > 0) begin
        checks++; if (o_dir_or !== e_dir || o_dir_and !== e_dir)
          $display("[TB] FAIL rand%0d_direction got=%b%b want=%b", i, o_dir_or, o_dir_and, e_dir); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_step_down_same();
    test_clamp_cflag();
    test_busy_load();
    test_reset_mid_move();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
